// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle for serial_adder_ctrl.
// The sub port exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;

    modport master (
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        output start, a, b, cin,
        input  busy, done, sum, carry
    );

    modport slave (
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        input  start, a, b, cin,
        output busy, done, sum, carry
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell, LSB first, one bit per clock.
// Optional subtract mode (a - b) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_adder_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] opa, opb, acc;
    logic             cr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             s, co, last;
    logic             busy_c, done_c;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    function automatic logic fa_sum(input logic x, input logic y, input logic z);
        return x ^ y ^ z;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    assign s    = fa_sum(opa[0], opb[0], cr);
    assign co   = fa_carry(opa[0], opb[0], cr);
    assign last = (cnt == LAST);

    // Subtraction is a + ~b + 1, so it reuses the adder with a forced carry-in.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load = bus.sub ? ~bus.b : bus.b;
    assign c_load = bus.sub ? 1'b1 : bus.cin;
`else
    assign b_load = bus.b;
    assign c_load = bus.cin;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: if (bus.start) state_nxt = RUN;
            RUN: begin
                busy_c = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                busy_c    = 1'b1;
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opa     <= '0;
            opb     <= '0;
            acc     <= '0;
            cr      <= 1'b0;
            cnt     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    opa <= bus.a;
                    opb <= b_load;
                    cr  <= c_load;
                    cnt <= '0;
                end
                RUN: begin
                    opa <= opa >> 1;
                    opb <= opb >> 1;
                    acc <= {s, acc[WIDTH-1:1]};
                    cr  <= co;
                    cnt <= cnt + 1'b1;
                    // Result registers see only the finished word, never a partial shift.
                    if (last) begin
                        sum_q   <= {s, acc[WIDTH-1:1]};
                        carry_q <= co;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = busy_c;
    assign bus.done  = done_c;
    assign bus.sum   = sum_q;
    assign bus.carry = carry_q;
endmodule
